// File: rtl/segdisplay_mux.sv
// rtl/segdisplay_mux.sv - multiplexed seven-segment display controller with register window
// Optional leading-zero suppression is built when SEGDISPLAY_LZS_EN is defined.
module segdisplay_mux #(
  parameter int DIGITS      = 8,
  parameter int CLK_DIVISOR = 32768
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [DIGITS-1:0] dsp_anode_o,
  output logic [7:0]        dsp_cathode_o,
  input  logic              chip_select_i,
  input  logic [1:0]        addr_i,
  output logic [31:0]       read_data_o,
  input  logic [31:0]       write_data_i,
  input  logic [3:0]        write_mask_i
);

  localparam int SW = $clog2(CLK_DIVISOR);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d;
  logic [3:0]          bright_q, bright_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;
  logic                lzs_bit;
`ifdef SEGDISPLAY_LZS_EN
  logic                lzs_q, lzs_d;
  assign lzs_bit = lzs_q;
`else
  assign lzs_bit = 1'b0;
`endif

  logic [31:0] rdata, wr_word;
  logic [3:0]  phase, nibble;
  logic        dp_bit, blank_bit, lit;
  logic [6:0]  glyph;

  // Read mux: digits beyond DIGITS are simply never placed into the word.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (addr_i == 2'(i / 8)) rdata[4*(i%8) +: 4] = value_q[4*i +: 4];
      if (addr_i == 2'd2) begin
        rdata[i]      = dp_q[i];
        rdata[16 + i] = blank_q[i];
      end
    end
    if (addr_i == 2'd3) rdata = {27'h0, lzs_bit, bright_q};
  end

  assign read_data_o = rdata;

  always_comb begin
    wr_word  = rdata;
    value_d  = value_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    bright_d = bright_q;
`ifdef SEGDISPLAY_LZS_EN
    lzs_d    = lzs_q;
`endif
    for (int b = 0; b < 4; b++) begin
      if (write_mask_i[b]) wr_word[8*b +: 8] = write_data_i[8*b +: 8];
    end
    if (chip_select_i) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (addr_i == 2'(i / 8)) value_d[4*i +: 4] = wr_word[4*(i%8) +: 4];
        if (addr_i == 2'd2) begin
          dp_d[i]    = wr_word[i];
          blank_d[i] = wr_word[16 + i];
        end
      end
      if (addr_i == 2'd3) begin
        bright_d = wr_word[3:0];
`ifdef SEGDISPLAY_LZS_EN
        lzs_d    = wr_word[4];
`endif
      end
    end
  end

  always_comb begin
    slot_d = slot_q + SW'(1);
    idx_d  = idx_q;
    if (slot_q == '1) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  always_comb begin
    phase     = slot_q[SW-1 -: 4];
    nibble    = '0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble    = value_q[4*i +: 4];
        dp_bit    = dp_q[i];
        blank_bit = blank_q[i];
      end
    end
  end

  always_comb begin
`ifdef SEGDISPLAY_LZS_EN
    logic [IW-1:0] hi;
    hi = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (value_q[4*i +: 4] != 4'h0) hi = IW'(i);
    end
`endif
    lit = (phase != 4'd0) && (phase <= bright_q) && !blank_bit;
`ifdef SEGDISPLAY_LZS_EN
    if (lzs_q && (idx_q > hi)) lit = 1'b0;
`endif
  end

  always_comb begin
    case (nibble)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) anode_d[i] = !(lit && (idx_q == IW'(i)));
    cathode_d = lit ? {!dp_bit, glyph} : 8'hFF;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q   <= '0;
      dp_q      <= '0;
      blank_q   <= '0;
      bright_q  <= 4'hF;
`ifdef SEGDISPLAY_LZS_EN
      lzs_q     <= 1'b0;
`endif
      slot_q    <= '0;
      idx_q     <= '0;
      anode_q   <= '1;
      cathode_q <= 8'hFF;
    end else begin
      value_q   <= value_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      bright_q  <= bright_d;
`ifdef SEGDISPLAY_LZS_EN
      lzs_q     <= lzs_d;
`endif
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign dsp_anode_o   = anode_q;
  assign dsp_cathode_o = cathode_q;

endmodule

// File: tb/tb_segdisplay_mux.sv
// tb/tb_segdisplay_mux.sv - self-checking bench for segdisplay_mux against a behavioural model
module tb_segdisplay_mux;
  localparam int D  = 8;
  localparam int D2 = 12;
  localparam int CD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [D-1:0]  an8;
  logic [7:0]    ca8;
  logic          cs;
  logic [1:0]    addr;
  logic [31:0]   rdata, wdata;
  logic [3:0]    wmask;
  logic [D2-1:0] an12;
  logic [7:0]    ca12;
  logic          cs2;
  logic [1:0]    addr2;
  logic [31:0]   rdata2, wdata2;
  logic [3:0]    wmask2;

  segdisplay_mux #(.DIGITS(D), .CLK_DIVISOR(CD)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .dsp_anode_o(an8), .dsp_cathode_o(ca8),
    .chip_select_i(cs), .addr_i(addr), .read_data_o(rdata),
    .write_data_i(wdata), .write_mask_i(wmask));

  segdisplay_mux #(.DIGITS(D2), .CLK_DIVISOR(CD)) u_dut12 (
    .clk_i(clk), .rst_ni(rst_n), .dsp_anode_o(an12), .dsp_cathode_o(ca12),
    .chip_select_i(cs2), .addr_i(addr2), .read_data_o(rdata2),
    .write_data_i(wdata2), .write_mask_i(wmask2));

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  m_val [16];
  logic [15:0] m_dp, m_blank;
  logic [3:0]  m_br;
  logic        m_lzs;
  logic [3:0]  m2_val [16];
  int          cyc;
  logic [6:0]  glyph [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_val[i]  = 4'h0;
      m2_val[i] = 4'h0;
    end
    m_dp = '0; m_blank = '0; m_br = 4'hF; m_lzs = 1'b0; cyc = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      if (int'(a) == i / 8) r[4*(i%8) +: 4] = m_val[i];
      if (a == 2'd2) begin
        r[i] = m_dp[i];
        r[16+i] = m_blank[i];
      end
    end
    if (a == 2'd3) r = {27'h0, m_lzs, m_br};
    return r;
  endfunction

  task automatic m_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = m_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    for (int i = 0; i < D; i++) begin
      if (int'(a) == i / 8) m_val[i] = w[4*(i%8) +: 4];
      if (a == 2'd2) begin
        m_dp[i] = w[i];
        m_blank[i] = w[16+i];
      end
    end
    if (a == 2'd3) begin
      m_br = w[3:0];
`ifdef SEGDISPLAY_LZS_EN
      m_lzs = w[4];
`endif
    end
  endtask

  // Display as a function of elapsed cycles: slot = c mod CD, digit = (c div CD) mod nd.
  task automatic exp_disp(input int nd, input int c, input logic [3:0] val [16],
                          input logic [15:0] dp, input logic [15:0] blank,
                          input logic [3:0] br, input logic lzs,
                          output logic [15:0] an, output logic [7:0] ca);
    int slot, d, phase, hi;
    slot = c % CD;
    d = (c / CD) % nd;
    phase = slot * 16 / CD;
    hi = 0;
    for (int i = 0; i < nd; i++) if (val[i] != 4'h0) hi = i;
    an = 16'hFFFF;
    ca = 8'hFF;
    if (phase != 0 && phase <= int'(br) && !blank[d] && !(lzs && d > hi)) begin
      an[d] = 1'b0;
      ca = {~dp[d], glyph[val[d]]};
    end
  endtask

  task automatic tick();
    logic [15:0] ea, ea2;
    logic [7:0]  ec, ec2;
    logic        rst_now, wr1, wr2;
    logic [1:0]  a1, a2;
    logic [31:0] d1, d2;
    logic [3:0]  mk1, mk2;
    rst_now = !rst_n;
    wr1 = cs && (wmask != 4'h0);   a1 = addr;  d1 = wdata;  mk1 = wmask;
    wr2 = cs2 && (wmask2 != 4'h0); a2 = addr2; d2 = wdata2; mk2 = wmask2;
    if (rst_now) begin
      ea = 16'hFFFF; ec = 8'hFF; ea2 = 16'hFFFF; ec2 = 8'hFF;
    end else begin
      exp_disp(D, cyc, m_val, m_dp, m_blank, m_br, m_lzs, ea, ec);
      exp_disp(D2, cyc, m2_val, 16'h0, 16'h0, 4'hF, 1'b0, ea2, ec2);
    end
    @(posedge clk);
    #1;
    if (rst_now) m_reset();
    else begin
      if (wr1) m_write(a1, d1, mk1);
      if (wr2) begin
        for (int i = 0; i < D2; i++)
          if (int'(a2) == i / 8 && mk2[(i%8)/2]) m2_val[i] = d2[4*(i%8) +: 4];
      end
      cyc++;
    end
    check("anode8", 32'(an8), 32'(ea[D-1:0]));
    check("cathode8", 32'(ca8), 32'(ec));
    check("anode12", 32'(an12), 32'(ea2[D2-1:0]));
    check("cathode12", 32'(ca12), 32'(ec2));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    cs = 1'b1; addr = a; wdata = d; wmask = m;
    #1;
    check("rd_prewrite", rdata, m_read(a));
    tick();
    cs = 1'b0; wmask = 4'h0;
    #1;
    check("rd_postwrite", rdata, m_read(a));
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_reset();
    rst_n = 1'b0;
    cs = 1'b0; addr = 2'd0; wdata = '0; wmask = 4'h0;
    cs2 = 1'b0; addr2 = 2'd0; wdata2 = '0; wmask2 = 4'h0;
    run(3);
    rst_n = 1'b1;

    cs2 = 1'b1; addr2 = 2'd1; wdata2 = 32'hFFFF_FFFF; wmask2 = 4'hF;
    tick();
    cs2 = 1'b0; wmask2 = 4'h0;
    #1;
    check("rd12_value_hi", rdata2, 32'h0000_FFFF);
    run(230);

    addr = 2'd3;
    #1;
    check("rd_ctrl_reset", rdata, 32'h0000_000F);

    bus_write(2'd0, 32'h1234_5678, 4'b0101);
    check("rd_value_lo_masked", rdata, 32'h0034_0078);
    run(40);
    bus_write(2'd2, 32'h0004_0002, 4'hF);
    run(60);
    bus_write(2'd3, 32'h0000_0003, 4'hF);
    run(130);
    bus_write(2'd3, 32'h0000_0000, 4'hF);
    run(40);
    bus_write(2'd2, 32'h0000_0000, 4'hF);
    bus_write(2'd3, 32'h0000_001F, 4'hF);
`ifdef SEGDISPLAY_LZS_EN
    check("rd_ctrl_lzs", rdata, 32'h0000_001F);
`else
    check("rd_ctrl_lzs", rdata, 32'h0000_000F);
`endif
    bus_write(2'd0, 32'h0000_0120, 4'hF);
    run(130);
    bus_write(2'd0, 32'h0000_0000, 4'hF);
    run(130);
    bus_write(2'd1, 32'hFFFF_FFFF, 4'hF);
    check("rd_value_hi_unstored", rdata, 32'h0000_0000);

    for (int it = 0; it < 300; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (it == 150) begin
        run(int'($urandom_range(1, 15)));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else if (r < 5) begin
        bus_write(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
      end else if (r == 5) begin
        addr = 2'($urandom_range(0, 3));
        #1;
        check("rd_random", rdata, m_read(addr));
      end else begin
        run(int'($urandom_range(1, 20)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
